// File: rtl/pwm_range_sequencer_if.sv
// Request/response bundle between the register-side requesters, the PWM
// divider and the range sequencer.
interface pwm_range_sequencer_if;
    localparam int unsigned RANGE_W = 16;

    logic [1:0]         req_valid;
    logic [RANGE_W-1:0] req_range0;
    logic [RANGE_W-1:0] req_range1;
    logic [1:0]         req_ready;
    logic               div_edge;
    logic [RANGE_W-1:0] range_out;
    logic               busy;
    logic               grant_id;
    logic               done;

    modport master (
        output req_valid, req_range0, req_range1, div_edge,
        input  req_ready, range_out, busy, grant_id, done
    );

    modport slave (
        input  req_valid, req_range0, req_range1, div_edge,
        output req_ready, range_out, busy, grant_id, done
    );
endinterface

// File: rtl/pwm_range_sequencer.sv
// Round-robin arbiter for two range-update requesters that ramps the PWM
// divider range toward the accepted target in bounded steps on divider edges.
module pwm_range_sequencer #(
    parameter logic [15:0] DEFAULT_RANGE  = 16'd1,
    parameter logic [15:0] STEP           = 16'd16,
    parameter logic [15:0] MAX_RANGE      = 16'hFFFF,
    parameter int unsigned SETTLE_EDGES   = 2,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000000
) (
    input  logic                  clk,
    input  logic                  rst,
    pwm_range_sequencer_if.slave  bus
);
    localparam int unsigned RANGE_W  = 16;
    localparam int unsigned TMO_W    = 32;
    localparam int unsigned SETTLE_W = (SETTLE_EDGES > 1) ? $clog2(SETTLE_EDGES + 1) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RAMP   = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;

    logic [1:0]          state_q,  state_d;
    logic [RANGE_W-1:0]  range_q,  range_d;
    logic [RANGE_W-1:0]  target_q, target_d;
    logic                grant_q,  grant_d;
    logic                rr_ptr_q, rr_ptr_d;
    logic [TMO_W-1:0]    tmo_q,    tmo_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic                done_q,   done_d;
    logic                busy_q,   busy_d;

    logic                sel_c;
    logic                accept_c;
    logic [1:0]          ready_c;
    logic [RANGE_W-1:0]  req_sel_c;
    logic [RANGE_W-1:0]  clamp_c;
    logic                up_c;
    logic [RANGE_W:0]    diff_c;
    logic [RANGE_W-1:0]  delta_c;
    logic [RANGE_W-1:0]  stepped_c;
    logic [TMO_W:0]      tmo_inc_c;
    logic                tmo_hit_c;
    logic [SETTLE_W-1:0] settle_inc_c;

    // Arbitration: a lone requester wins; on contention the pointer decides.
    always_comb begin
        sel_c = bus.req_valid[1];
        if (bus.req_valid == 2'b11) begin
            sel_c = rr_ptr_q;
        end
        accept_c = (state_q == S_IDLE) && (bus.req_valid != 2'b00);
        ready_c  = 2'b00;
        if (accept_c) begin
            ready_c = sel_c ? 2'b10 : 2'b01;
        end
    end

    // Requested value with zero promoted to one and the top clamped.
    always_comb begin
        req_sel_c = sel_c ? bus.req_range1 : bus.req_range0;
        clamp_c   = req_sel_c;
        if (req_sel_c == '0) begin
            clamp_c = RANGE_W'(1);
        end else if (req_sel_c > MAX_RANGE) begin
            clamp_c = MAX_RANGE;
        end
    end

    // One bounded step toward target; distance taken 17-bit so it cannot wrap.
    always_comb begin
        up_c = target_q > range_q;
        if (up_c) begin
            diff_c = {1'b0, target_q} - {1'b0, range_q};
        end else begin
            diff_c = {1'b0, range_q} - {1'b0, target_q};
        end
        delta_c = (diff_c > {1'b0, STEP}) ? STEP : diff_c[RANGE_W-1:0];
        stepped_c = up_c ? (range_q + delta_c) : (range_q - delta_c);
    end

    always_comb begin
        tmo_inc_c    = {1'b0, tmo_q} + (TMO_W+1)'(1);
        tmo_hit_c    = tmo_inc_c >= {1'b0, TIMEOUT_CYCLES};
        settle_inc_c = settle_q + SETTLE_W'(1);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        range_d  = range_q;
        target_d = target_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        tmo_d    = tmo_q;
        settle_d = settle_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    target_d = clamp_c;
                    grant_d  = sel_c;
                    rr_ptr_d = ~sel_c;
                    tmo_d    = '0;
                    settle_d = '0;
                    if (clamp_c == range_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_RAMP;
                    end
                end
            end

            S_RAMP: begin
                if (bus.div_edge) begin
                    tmo_d   = '0;
                    range_d = stepped_c;
                    if (stepped_c == target_q) begin
                        if (SETTLE_EDGES == 0) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            settle_d = '0;
                            state_d  = S_SETTLE;
                        end
                    end
                end else if (tmo_hit_c) begin
                    // Divider stalled: jump straight to target and skip settling.
                    tmo_d   = '0;
                    range_d = target_q;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_inc_c[TMO_W-1:0];
                end
            end

            S_SETTLE: begin
                if (bus.div_edge) begin
                    if (settle_inc_c == SETTLE_W'(SETTLE_EDGES)) begin
                        settle_d = '0;
                        done_d   = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        settle_d = settle_inc_c;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            range_q  <= DEFAULT_RANGE;
            target_q <= DEFAULT_RANGE;
            grant_q  <= 1'b0;
            rr_ptr_q <= 1'b0;
            tmo_q    <= '0;
            settle_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            range_q  <= range_d;
            target_q <= target_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            tmo_q    <= tmo_d;
            settle_q <= settle_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.range_out = range_q;
    assign bus.busy      = busy_q;
    assign bus.grant_id  = grant_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_pwm_range_sequencer.sv
// Randomized self-checking bench for pwm_range_sequencer against a
// transaction-level model of the ramp, settle and timeout rules.
module tb_pwm_range_sequencer;
    localparam int STEP   = 16;
    localparam int SETTLE = 2;
    localparam int TMO    = 50;

    logic clk = 1'b0;
    logic rst;

    pwm_range_sequencer_if ifc();

    pwm_range_sequencer #(
        .DEFAULT_RANGE (16'd1),
        .STEP          (16'(STEP)),
        .MAX_RANGE     (16'hFFFF),
        .SETTLE_EDGES  (SETTLE),
        .TIMEOUT_CYCLES(32'(TMO))
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int m_range;
    int m_ptr;
    int m_grant;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int min_m(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int clamp_m(input int v);
        if (v == 0) return 1;
        if (v > 65535) return 65535;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input int range, input int busy, input int done);
        check_eq({tag, ".range"}, 32'(ifc.range_out), 32'(range));
        check_eq({tag, ".busy"},  32'(ifc.busy),      32'(busy));
        check_eq({tag, ".done"},  32'(ifc.done),      32'(done));
        check_eq({tag, ".grant"}, 32'(ifc.grant_id),  32'(m_grant));
    endtask

    // A cycle spent busy with random requests that must all be held off.
    task automatic busy_cycle(input string tag, input int range);
        ifc.req_valid  = 2'($urandom_range(0, 3));
        ifc.req_range0 = 16'($urandom_range(0, 65535));
        ifc.req_range1 = 16'($urandom_range(0, 65535));
        #1;
        check_eq({tag, ".ready"}, 32'(ifc.req_ready), 32'(0));
        step();
        ifc.req_valid = 2'b00;
        check_outs(tag, range, 1, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifc.req_valid = 2'b00;
        ifc.req_range0 = 16'd0;
        ifc.req_range1 = 16'd0;
        ifc.div_edge = 1'b0;
        repeat (3) step();
        m_range = 1;
        m_ptr   = 0;
        m_grant = 0;
        check_outs("in_reset", 1, 0, 0);
        check_eq("in_reset.ready", 32'(ifc.req_ready), 32'(0));
        rst = 1'b0;
        step();
        check_outs("post_reset", 1, 0, 0);
    endtask

    // One request: expected ramp is the list of values reached by bounded steps.
    task automatic run_req(input logic [1:0] v, input int r0, input int r1,
                           input int gap_max, input int stall_after);
        int win, tgt, cur, prev, gap;
        int seq[$];
        win = (v == 2'b11) ? m_ptr : (v[1] ? 1 : 0);
        tgt = clamp_m((win == 1) ? r1 : r0);
        cur = m_range;
        while (cur != tgt) begin
            cur = (tgt > cur) ? cur + min_m(STEP, tgt - cur) : cur - min_m(STEP, cur - tgt);
            seq.push_back(cur);
        end

        ifc.req_valid  = v;
        ifc.req_range0 = 16'(r0);
        ifc.req_range1 = 16'(r1);
        ifc.div_edge   = 1'($urandom_range(0, 1));
        #1;
        check_eq("req_ready", 32'(ifc.req_ready), 32'((win == 1) ? 2 : 1));
        step();
        ifc.req_valid = 2'b00;
        ifc.div_edge  = 1'b0;
        m_ptr   = 1 - win;
        m_grant = win;

        if (seq.size() == 0) begin
            check_outs("noop", m_range, 0, 1);
            step();
            check_outs("noop_after", m_range, 0, 0);
            return;
        end

        check_outs("accept", m_range, 1, 0);
        prev = m_range;
        foreach (seq[k]) begin
            if (k == stall_after) begin
                repeat (TMO - 1) busy_cycle("stall", prev);
                step();
                m_range = tgt;
                check_outs("timeout", tgt, 0, 1);
                step();
                check_outs("timeout_after", tgt, 0, 0);
                return;
            end
            gap = $urandom_range(0, gap_max);
            repeat (gap) busy_cycle("ramp_gap", prev);
            ifc.div_edge = 1'b1;
            step();
            ifc.div_edge = 1'b0;
            check_outs("ramp_step", seq[k], 1, 0);
            prev = seq[k];
        end

        m_range = tgt;
        for (int s = 0; s < SETTLE; s++) begin
            gap = $urandom_range(0, gap_max);
            repeat (gap) busy_cycle("settle_gap", tgt);
            ifc.div_edge = 1'b1;
            step();
            ifc.div_edge = 1'b0;
            check_outs("settle_edge", tgt, (s == SETTLE - 1) ? 0 : 1, (s == SETTLE - 1) ? 1 : 0);
        end
        step();
        check_outs("done_after", tgt, 0, 0);
    endtask

    initial begin
        int v, r0, r1, stall;
        do_reset();

        // Ramp up then back down.
        run_req(2'b01, 50, 0, 3, -1);
        run_req(2'b10, 0, 10, 3, -1);

        // Contention after reset alternates starting from requester 0.
        do_reset();
        run_req(2'b11, 60, 30, 2, -1);
        run_req(2'b11, 90, 30, 2, -1);
        run_req(2'b11, 5, 30, 2, -1);

        // Zero promotes to one, which matches the current range.
        do_reset();
        run_req(2'b01, 0, 0, 2, -1);

        // Divider stalled for the whole ramp.
        run_req(2'b10, 0, 200, 2, 0);

        // Asynchronous reset in the middle of a ramp.
        do_reset();
        ifc.req_valid  = 2'b01;
        ifc.req_range0 = 16'd50;
        step();
        ifc.req_valid = 2'b00;
        ifc.div_edge  = 1'b1;
        step();
        step();
        ifc.div_edge = 1'b0;
        m_grant = 0;
        check_outs("pre_async", 33, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        m_range = 1;
        m_ptr   = 0;
        check_outs("async_rst", 1, 0, 0);
        step();
        rst = 1'b0;
        repeat (3) begin
            step();
            check_outs("post_async", 1, 0, 0);
        end
        run_req(2'b01, 40, 0, 2, -1);

        // Randomized traffic.
        for (int t = 0; t < 30; t++) begin
            v = $urandom_range(1, 3);
            r0 = 0;
            r1 = 0;
            case ($urandom_range(0, 3))
                0: r0 = 0;
                1: r0 = m_range;
                2: r0 = $urandom_range(1, 400);
                default: begin
                    r0 = m_range + $urandom_range(0, 80) - 40;
                    if (r0 < 0) r0 = 0;
                end
            endcase
            r1 = (($urandom_range(0, 1)) == 1) ? $urandom_range(0, 400) : r0 + 3;
            stall = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 5) : -1;
            run_req(2'(v), r0, r1, 4, stall);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
